day3_loader: RTL
================

DAY3_LOADER -- requirements
Module: day3_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 4096, number of memory words written (address width 12).
REQ-002 SHALL have parameter MAX_LINE, default 64, maximum items per line (width of the solver's half bitmaps).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  ASCII character present.
REQ-006 SHALL have port in_data  input  8  ASCII character.
REQ-007 SHALL have port in_last  input  1  qualifies final character of the input file.
REQ-008 SHALL have port in_ready  output  1  character accepted when in_valid & in_ready.
REQ-009 SHALL have port wr_en  output  1  memory write strobe.
REQ-010 SHALL have port wr_addr  output  12  memory write address.
REQ-011 SHALL have port wr_data  output  8  item priority 1..52, or 0 as terminator.
REQ-012 SHALL have port line_count  output  16  lines written so far.
REQ-013 SHALL have port error  output  1  sticky; bad char, odd line, overlong line or overflow.
REQ-014 SHALL have port done  output  1  image complete; held until reset.

Function
REQ-015 SHALL encode 'a'..'z' as 1..26 and 'A'..'Z' as 27..52.
REQ-016 SHALL register each write: wr_en/wr_addr/wr_data valid the cycle after the accepting handshake (latency 1), one write per cycle max.
REQ-017 SHALL start writes at address 0, increment by 1 per write, never skip or rewrite an address.
REQ-018 SHALL write each accepted letter's priority and increment the current line length.
REQ-019 SHALL, on '\n' with line length > 0, write 0, increment line_count, clear line length.
REQ-020 SHALL accept '\n' on an empty line, and any '\r', without writing; empty lines are never emitted.
REQ-021 SHALL set error on a terminated line of odd length; the line is still written.
REQ-022 SHALL set error on any other character, accept it, and write nothing.
REQ-023 SHALL set error on a letter that would make line length exceed MAX_LINE; that letter is dropped.
REQ-024 SHALL use states IDLE, LOAD, TERM, SENTINEL, DONE; IDLE->LOAD the cycle after reset deasserts.
REQ-025 SHALL drive in_ready high only in LOAD.
REQ-026 SHALL, on an accepted in_last in LOAD, process that character, then go to TERM; TERM writes 0 if line length > 0 (increments line_count), then SENTINEL.
REQ-027 SHALL, in SENTINEL, write one extra 0 (double zero = end of file), then go to DONE.
REQ-028 SHALL reserve the top two addresses: a letter that would be written at or above MEM_DEPTH-2 is dropped, error set, state forced to TERM.
REQ-029 SHALL, in DONE, hold in_ready=0 and done=1 and issue no writes; further input is ignored.
REQ-030 SHALL keep line_count saturating at 16'hFFFF.

Reset
REQ-031 SHALL, while rst=1, clear state to IDLE and set in_ready, wr_en, wr_addr, wr_data, line_count, error and done to 0.
REQ-032 SHALL abort on rst mid-load: no further writes, and the next load restarts at address 0.

Structure
REQ-033 SHALL place state encodings, ASCII bounds, MEM_DEPTH and the priority constants (1, 26, 27, 52) in shared package day3_pkg, shared with the solver.
REQ-034 SHALL implement ASCII->priority in combinational sub-module day3_prio_enc: output 0 means not a letter.

Verification
REQ-035 SHALL stream "vJrwpWtwJgWrhcsFMMfFFhFp\n" with in_last on '\n' -> writes addr 0..23 (addr0=22, addr1=36), addr24=0, addr25=0; line_count=1; done; error=0.
REQ-036 SHALL stream "ab" with in_last on 'b' and no newline -> addr0=1, addr1=2, addr2=0, addr3=0; line_count=1.
REQ-037 SHALL stream "abc\n\n\r\nZz\n" -> odd line sets error; writes 1,2,3,0,52,26,0 at addr 0..6; line_count=2.
REQ-038 SHALL include "a1b\n" -> error=1; writes 1,2,0 only.
REQ-039 SHALL fill with 2-char lines until overflow -> no write above address 4095; last two writes are 0; done=1; error=1.
REQ-040 SHALL pulse rst after 10 characters -> wr_en low from the next cycle; reload writes from address 0; line_count restarts at 0.

Source files
------------

// File: rtl/day3_pkg.sv
// Shared constants and types for the day-3 rucksack loader and solver:
// FSM encoding, ASCII letter bounds, memory geometry and item priority ranges.
package day3_pkg;

  localparam int MEM_DEPTH = 4096;
  localparam int ADDR_W    = 12;
  localparam int MAX_LINE  = 64;

  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;
  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_UC_Z = 8'h5A;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  localparam logic [7:0] PRIO_LC_MIN = 8'd1;
  localparam logic [7:0] PRIO_LC_MAX = 8'd26;
  localparam logic [7:0] PRIO_UC_MIN = 8'd27;
  localparam logic [7:0] PRIO_UC_MAX = 8'd52;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TERM,
    SENTINEL,
    DONE
  } state_t;

  // A priority value denotes an item only inside one of the two letter ranges.
  function automatic logic prio_valid(input logic [7:0] p);
    return ((p >= PRIO_LC_MIN) && (p <= PRIO_LC_MAX)) ||
           ((p >= PRIO_UC_MIN) && (p <= PRIO_UC_MAX));
  endfunction

endpackage

// File: rtl/day3_prio_enc.sv
// ASCII character to item priority; a result of 0 means the character is not a letter.
module day3_prio_enc
  import day3_pkg::*;
(
  input  logic [7:0] ch,
  output logic [7:0] prio
);

  always_comb begin
    prio = '0;
    if ((ch >= ASCII_LC_A) && (ch <= ASCII_LC_Z))
      prio = PRIO_LC_MIN + (ch - ASCII_LC_A);
    else if ((ch >= ASCII_UC_A) && (ch <= ASCII_UC_Z))
      prio = PRIO_UC_MIN + (ch - ASCII_UC_A);
  end

endmodule

// File: rtl/day3_loader.sv
// Streams an ASCII rucksack list into memory as priorities, one 0 after each
// line and a second 0 at end of file, so the solver sees a double-zero terminator.
module day3_loader #(
  parameter int MEM_DEPTH = day3_pkg::MEM_DEPTH,
  parameter int MAX_LINE  = day3_pkg::MAX_LINE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic                        wr_en,
  output logic [day3_pkg::ADDR_W-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  output logic [15:0]                 line_count,
  output logic                        error,
  output logic                        done
);
  import day3_pkg::*;

  localparam int LEN_W = $clog2(MAX_LINE + 1);
  localparam logic [LEN_W-1:0]  LEN_MAX    = LEN_W'(MAX_LINE);
  // The top two words are kept free for the final line terminator and the sentinel.
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W+1)'(MEM_DEPTH - 2);
  localparam logic [ADDR_W:0]   ADDR_ONE   = (ADDR_W+1)'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE    = LEN_W'(1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             state_q, state_d;
  logic [ADDR_W:0]    addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         prio;
  logic               accept;
  logic               wr_en_p0;
  logic [7:0]         wr_data_p0;
  logic               lc_inc;
  logic               err_set;

  day3_prio_enc u_prio_enc (
    .ch   (in_data),
    .prio (prio)
  );

  assign in_ready = (state_q == LOAD) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wr_en_p0   = 1'b0;
    wr_data_p0 = '0;
    lc_inc     = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (accept) begin
          if (prio_valid(prio)) begin
            if (addr_q >= ADDR_LIMIT) begin
              err_set = 1'b1;
              state_d = TERM;
            end else if (len_q == LEN_MAX) begin
              err_set = 1'b1;
            end else begin
              wr_en_p0   = 1'b1;
              wr_data_p0 = prio;
              addr_d     = addr_q + ADDR_ONE;
              len_d      = len_q + LEN_ONE;
            end
          end else if (in_data == ASCII_LF) begin
            if (len_q != '0) begin
              wr_en_p0 = 1'b1;
              addr_d   = addr_q + ADDR_ONE;
              len_d    = '0;
              lc_inc   = 1'b1;
              err_set  = len_q[0];
            end
          end else if (in_data != ASCII_CR) begin
            err_set = 1'b1;
          end
          if (in_last)
            state_d = TERM;
        end
      end
      // Close a line left open by end of file or by memory overflow.
      TERM: begin
        if (len_q != '0) begin
          wr_en_p0 = 1'b1;
          addr_d   = addr_q + ADDR_ONE;
          len_d    = '0;
          lc_inc   = 1'b1;
          err_set  = len_q[0];
        end
        state_d = SENTINEL;
      end
      SENTINEL: begin
        wr_en_p0 = 1'b1;
        addr_d   = addr_q + ADDR_ONE;
        state_d  = DONE;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // p0 -> p1: register the write port and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      line_count <= '0;
      error      <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wr_en   <= wr_en_p0;
      if (wr_en_p0) begin
        wr_addr <= addr_q[ADDR_W-1:0];
        wr_data <= wr_data_p0;
      end
      if (lc_inc)
        line_count <= sat_inc16(line_count);
      if (err_set)
        error <= 1'b1;
      done <= (state_d == DONE);
    end
  end

endmodule
